// File: rtl/frame_scheduler.sv
// -----------------------------------------------------------------------------
// frame_scheduler
//
// Purpose:
//   Coordinates capture of a "static" reference frame into a BRAM and the
//   correlator that consumes it. The scheduler waits for a frame boundary,
//   opens the BRAM write gate for exactly one camera frame, freezes the BRAM,
//   pulses corr_start and then waits for the correlator to finish before
//   re-arming. Camera frames that end while the correlator is busy are
//   counted as dropped.
//
// Optional feature:
//   `define FRAME_SCHEDULER_WATCHDOG_EN to enable a watchdog that aborts a
//   correlation pass lasting WDOG_CYCLES cycles and sets a sticky timeout
//   flag. Without it, timeout is tied low and CORR waits indefinitely.
//
// Parameters:
//   FRAME_PIXELS  pixels per captured frame; eof is cap_addr == FRAME_PIXELS-1
//   WDOG_CYCLES   maximum GCLK cycles allowed for one correlation pass
//
// Ports:
//   GCLK           in   system clock
//   reset          in   synchronous, active-high reset
//   cap_addr[18:0] in   camera write address (already in the GCLK domain)
//   tracking_mode  in   level, 1 = tracking requested
//   corr_done      in   one-cycle pulse, correlator finished a pass
//   static_we      out  write-enable gate for the static frame BRAM
//   corr_start     out  one-cycle pulse, static frame may be correlated
//   frozen         out  high while the static frame is stable (START, CORR)
//   state[2:0]     out  current state (IDLE=0 ARM=1 FILL=2 START=3 CORR=4)
//   frame_count    out  completed correlation passes, wraps 65535 -> 0
//   dropped        out  eofs seen during CORR, saturates at 255
//   timeout        out  sticky watchdog-expiry flag
// -----------------------------------------------------------------------------
module frame_scheduler #(
    parameter int FRAME_PIXELS = 307200,
    parameter int WDOG_CYCLES  = 2000000
) (
    input  logic        GCLK,
    input  logic        reset,
    input  logic [18:0] cap_addr,
    input  logic        tracking_mode,
    input  logic        corr_done,
    output logic        static_we,
    output logic        corr_start,
    output logic        frozen,
    output logic [2:0]  state,
    output logic [15:0] frame_count,
    output logic [7:0]  dropped,
    output logic        timeout
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_FILL  = 3'd2,
        ST_START = 3'd3,
        ST_CORR  = 3'd4
    } state_t;

    localparam logic [18:0] LAST_ADDR = 19'(FRAME_PIXELS - 1);

    state_t      state_q, state_d;
    logic [18:0] prev_addr_q;
    logic        static_we_q, static_we_d;
    logic        corr_start_q, corr_start_d;
    logic        frozen_q, frozen_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic [7:0]  dropped_q, dropped_d;
    logic        eof;
    logic        wdog_expire;

    // The camera may park on the last address for several cycles; only the
    // cycle on which the address arrives there counts as end-of-frame.
    assign eof = (cap_addr == LAST_ADDR) && (cap_addr != prev_addr_q);

`ifdef FRAME_SCHEDULER_WATCHDOG_EN
    localparam int                WDOG_W    = $clog2(WDOG_CYCLES) + 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              timeout_q, timeout_d;

    // Counter reads 0 in the first CORR cycle and k in the k-th; it can
    // never pass WDOG_LAST because CORR is left on that cycle.
    always_comb begin
        wdog_d    = '0;
        timeout_d = timeout_q;
        if (state_q == ST_CORR) begin
            wdog_d = wdog_q + 1'b1;
        end
        // A corr_done on the expiry cycle is a normal completion.
        if (wdog_expire && !corr_done) begin
            timeout_d = 1'b1;
        end
    end

    assign wdog_expire = (state_q == ST_CORR) && (wdog_q == WDOG_LAST);

    always_ff @(posedge GCLK) begin
        if (reset) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    // WDOG_CYCLES has no effect in this build.
    if (WDOG_CYCLES < 1) begin : g_wdog_cfg_unused
    end

    assign wdog_expire = 1'b0;
    assign timeout     = 1'b0;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        frame_count_d = frame_count_q;
        dropped_d     = dropped_q;

        case (state_q)
            ST_IDLE: begin
                if (tracking_mode) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (!tracking_mode) begin
                    state_d = ST_IDLE;
                end else if (eof) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (!tracking_mode) begin
                    state_d = ST_IDLE;
                end else if (eof) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (!tracking_mode) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CORR;
                end
            end
            ST_CORR: begin
                if (eof && (dropped_q != 8'hFF)) begin
                    dropped_d = dropped_q + 8'd1;
                end
                if (corr_done) begin
                    frame_count_d = frame_count_q + 16'd1;
                    state_d       = tracking_mode ? ST_ARM : ST_IDLE;
                end else if (wdog_expire) begin
                    state_d = tracking_mode ? ST_ARM : ST_IDLE;
                end else if (!tracking_mode) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so the flops track the
        // state register exactly. corr_start is raised only when START
        // actually commits to CORR, so an aborted START emits nothing.
        static_we_d  = (state_d == ST_FILL);
        frozen_d     = (state_d == ST_START) || (state_d == ST_CORR);
        corr_start_d = (state_q == ST_START) && (state_d == ST_CORR);
    end

    always_ff @(posedge GCLK) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            prev_addr_q   <= '0;
            static_we_q   <= 1'b0;
            corr_start_q  <= 1'b0;
            frozen_q      <= 1'b0;
            frame_count_q <= '0;
            dropped_q     <= '0;
        end else begin
            state_q       <= state_d;
            prev_addr_q   <= cap_addr;
            static_we_q   <= static_we_d;
            corr_start_q  <= corr_start_d;
            frozen_q      <= frozen_d;
            frame_count_q <= frame_count_d;
            dropped_q     <= dropped_d;
        end
    end

    assign static_we   = static_we_q;
    assign corr_start  = corr_start_q;
    assign frozen      = frozen_q;
    assign state       = state_q;
    assign frame_count = frame_count_q;
    assign dropped     = dropped_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_frame_scheduler
//
// Purpose: self-checking bench for frame_scheduler using small frames
// (FRAME_PIXELS=16) and WDOG_CYCLES=100. Directed scenario tasks plus a
// randomized run compared against a behavioural model of the scheduling rules.
// Define FRAME_SCHEDULER_WATCHDOG_EN to also exercise the watchdog.
// -----------------------------------------------------------------------------
module tb_frame_scheduler;

    localparam int FP = 16;
    localparam int WD = 100;

    logic        GCLK = 1'b0;
    logic        reset = 1'b1;
    logic [18:0] cap_addr = '0;
    logic        tracking_mode = 1'b0;
    logic        corr_done = 1'b0;
    logic        static_we, corr_start, frozen, timeout;
    logic [2:0]  state;
    logic [15:0] frame_count;
    logic [7:0]  dropped;

    int checks = 0;
    int errors = 0;
    int we_cycles = 0;
    int cs_count = 0;

    frame_scheduler #(
        .FRAME_PIXELS(FP),
        .WDOG_CYCLES (WD)
    ) dut (
        .GCLK         (GCLK),
        .reset        (reset),
        .cap_addr     (cap_addr),
        .tracking_mode(tracking_mode),
        .corr_done    (corr_done),
        .static_we    (static_we),
        .corr_start   (corr_start),
        .frozen       (frozen),
        .state        (state),
        .frame_count  (frame_count),
        .dropped      (dropped),
        .timeout      (timeout)
    );

    always #5 GCLK = ~GCLK;

    // One clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge GCLK);
        #1;
        if (static_we === 1'b1) we_cycles++;
        if (corr_start === 1'b1) cs_count++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tracking_mode = 1'b0;
        corr_done = 1'b0;
        cap_addr = '0;
        tick();
        tick();
        reset = 1'b0;
        we_cycles = 0;
        cs_count = 0;
    endtask

    // Sweep camera addresses until the DUT reports the target state.
    task automatic advance_to(input int target, input string name);
        int n = 0;
        checks++;
        while (state !== 3'(target) && n < 200) begin
            cap_addr = (cap_addr == 19'(FP - 1)) ? 19'd0 : cap_addr + 19'd1;
            tick();
            n++;
        end
        if (state !== 3'(target)) begin
            errors++;
            $display("FAIL reach_%s: state=%0d required=%0d", name, state, target);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tracking_mode = 1'b1;
        corr_done = 1'b1;
        cap_addr = 19'(FP - 1);
        repeat (3) tick();
        checks += 7;
        if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got=%0d exp=0", state); end
        if (static_we !== 1'b0) begin errors++; $display("FAIL reset_static_we: got=%b exp=0", static_we); end
        if (corr_start !== 1'b0) begin errors++; $display("FAIL reset_corr_start: got=%b exp=0", corr_start); end
        if (frozen !== 1'b0) begin errors++; $display("FAIL reset_frozen: got=%b exp=0", frozen); end
        if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_frame_count: got=%0d exp=0", frame_count); end
        if (dropped !== 8'd0) begin errors++; $display("FAIL reset_dropped: got=%0d exp=0", dropped); end
        if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got=%b exp=0", timeout); end
        $display("test_reset: state=%0d fc=%0d dropped=%0d", state, frame_count, dropped);
        corr_done = 1'b0;
        cap_addr = '0;
        reset = 1'b0;
    endtask

    // tracking on, two full frames, corr_done 10 cycles after the second eof.
    task automatic test_basic();
        do_reset();
        tracking_mode = 1'b1;
        tick();
        checks++;
        if (state !== 3'd1) begin errors++; $display("FAIL basic_arm: state=%0d exp=1", state); end
        for (int a = 0; a < FP; a++) begin cap_addr = 19'(a); tick(); end
        checks++;
        if (state !== 3'd2) begin errors++; $display("FAIL basic_fill: state=%0d exp=2", state); end
        for (int a = 0; a < FP; a++) begin cap_addr = 19'(a); tick(); end
        checks += 3;
        if (state !== 3'd3) begin errors++; $display("FAIL basic_start: state=%0d exp=3", state); end
        if (frozen !== 1'b1) begin errors++; $display("FAIL basic_frozen: got=%b exp=1", frozen); end
        if (static_we !== 1'b0) begin errors++; $display("FAIL basic_we_drop: got=%b exp=0", static_we); end
        cap_addr = '0;
        tick();
        checks += 2;
        if (state !== 3'd4) begin errors++; $display("FAIL basic_corr: state=%0d exp=4", state); end
        if (corr_start !== 1'b1) begin errors++; $display("FAIL basic_corr_start: got=%b exp=1", corr_start); end
        repeat (8) tick();
        corr_done = 1'b1;
        tick();
        corr_done = 1'b0;
        tick();
        checks += 5;
        if (frame_count !== 16'd1) begin errors++; $display("FAIL basic_frame_count: got=%0d exp=1", frame_count); end
        if (state !== 3'd1) begin errors++; $display("FAIL basic_rearm: state=%0d exp=1", state); end
        if (we_cycles != FP) begin errors++; $display("FAIL basic_we_cycles: got=%0d exp=%0d", we_cycles, FP); end
        if (cs_count != 1) begin errors++; $display("FAIL basic_corr_start_count: got=%0d exp=1", cs_count); end
        if (frozen !== 1'b0) begin errors++; $display("FAIL basic_unfrozen: got=%b exp=0", frozen); end
        $display("test_basic: fc=%0d we_cycles=%0d corr_starts=%0d state=%0d", frame_count, we_cycles, cs_count, state);
    endtask

    // Address parked on the last pixel for 50 cycles is a single eof (ARM->FILL only).
    task automatic test_hold_eof();
        cap_addr = 19'(FP - 1);
        repeat (50) tick();
        checks++;
        if (state !== 3'd2) begin errors++; $display("FAIL hold_eof_state: got=%0d exp=2", state); end
        $display("test_hold_eof: state=%0d after 50 held cycles", state);
    endtask

    task automatic test_abort();
        cs_count = 0;
        tracking_mode = 1'b0;
        cap_addr = 19'd5;
        tick();
        checks += 2;
        if (state !== 3'd0) begin errors++; $display("FAIL abort_fill_state: got=%0d exp=0", state); end
        if (static_we !== 1'b0) begin errors++; $display("FAIL abort_fill_we: got=%b exp=0", static_we); end
        tracking_mode = 1'b1;
        tick();
        advance_to(3, "start");
        tracking_mode = 1'b0;
        tick();
        checks += 2;
        if (state !== 3'd0) begin errors++; $display("FAIL abort_start_state: got=%0d exp=0", state); end
        if (corr_start !== 1'b0) begin errors++; $display("FAIL abort_start_pulse: got=%b exp=0", corr_start); end
        repeat (3) tick();
        checks++;
        if (cs_count != 0) begin errors++; $display("FAIL abort_no_corr_start: got=%0d exp=0", cs_count); end
        $display("test_abort: state=%0d corr_starts=%0d", state, cs_count);
    endtask

    // 300 eofs presented while the DUT reports CORR; dropped must saturate.
    task automatic test_dropped();
        int ev = 0;
        int n = 0;
        do_reset();
        tracking_mode = 1'b1;
        while (ev < 300 && n < 20000) begin
            if (state === 3'd4) begin
                if (cap_addr == 19'(FP - 1)) cap_addr = '0;
                else begin cap_addr = 19'(FP - 1); ev++; end
            end else begin
                cap_addr = (cap_addr == 19'(FP - 1)) ? 19'd0 : cap_addr + 19'd1;
            end
            tick();
            n++;
        end
        checks += 2;
        if (ev < 300) begin errors++; $display("FAIL dropped_budget: eofs=%0d exp=300", ev); end
        if (dropped !== 8'd255) begin errors++; $display("FAIL dropped_saturate: got=%0d exp=255", dropped); end
        $display("test_dropped: eofs_in_corr=%0d dropped=%0d", ev, dropped);
    endtask

    task automatic test_watchdog();
`ifdef FRAME_SCHEDULER_WATCHDOG_EN
        logic [15:0] fc0;
        do_reset();
        tracking_mode = 1'b1;
        tick();
        advance_to(4, "corr_wd1");
        fc0 = frame_count;
        repeat (99) tick();
        checks += 2;
        if (state !== 3'd4) begin errors++; $display("FAIL wd_cycle99_state: got=%0d exp=4", state); end
        if (timeout !== 1'b0) begin errors++; $display("FAIL wd_cycle99_timeout: got=%b exp=0", timeout); end
        tick();
        checks += 3;
        if (timeout !== 1'b1) begin errors++; $display("FAIL wd_expire_timeout: got=%b exp=1", timeout); end
        if (state !== 3'd1) begin errors++; $display("FAIL wd_expire_state: got=%0d exp=1", state); end
        if (frame_count !== fc0) begin errors++; $display("FAIL wd_expire_fc: got=%0d exp=%0d", frame_count, fc0); end
        $display("test_watchdog expire: timeout=%b state=%0d fc=%0d", timeout, state, frame_count);
        do_reset();
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL wd_reset_clear: got=%b exp=0", timeout); end
        tracking_mode = 1'b1;
        tick();
        advance_to(4, "corr_wd2");
        repeat (99) tick();
        corr_done = 1'b1;
        tick();
        corr_done = 1'b0;
        checks += 3;
        if (frame_count !== 16'd1) begin errors++; $display("FAIL wd_done_wins_fc: got=%0d exp=1", frame_count); end
        if (timeout !== 1'b0) begin errors++; $display("FAIL wd_done_wins_timeout: got=%b exp=0", timeout); end
        if (state !== 3'd1) begin errors++; $display("FAIL wd_done_wins_state: got=%0d exp=1", state); end
        $display("test_watchdog done-wins: timeout=%b state=%0d fc=%0d", timeout, state, frame_count);
`else
        do_reset();
        tracking_mode = 1'b1;
        tick();
        advance_to(4, "corr_nowd");
        repeat (150) tick();
        checks += 2;
        if (state !== 3'd4) begin errors++; $display("FAIL nowd_state: got=%0d exp=4", state); end
        if (timeout !== 1'b0) begin errors++; $display("FAIL nowd_timeout: got=%b exp=0", timeout); end
        $display("test_watchdog disabled: state=%0d timeout=%b after 150 CORR cycles", state, timeout);
`endif
    endtask

    task automatic test_ignored_done();
        do_reset();
        corr_done = 1'b1;
        tick();
        corr_done = 1'b0;
        tick();
        checks += 2;
        if (state !== 3'd0) begin errors++; $display("FAIL done_idle_state: got=%0d exp=0", state); end
        if (frame_count !== 16'd0) begin errors++; $display("FAIL done_idle_fc: got=%0d exp=0", frame_count); end
        tracking_mode = 1'b1;
        tick();
        advance_to(2, "fill");
        corr_done = 1'b1;
        tick();
        corr_done = 1'b0;
        checks += 2;
        if (state !== 3'd2) begin errors++; $display("FAIL done_fill_state: got=%0d exp=2", state); end
        if (frame_count !== 16'd0) begin errors++; $display("FAIL done_fill_fc: got=%0d exp=0", frame_count); end
        $display("test_ignored_done: state=%0d fc=%0d", state, frame_count);
    endtask

    // ---------------- behavioural model of the scheduling rules --------------
    int m_state, m_prev, m_fc, m_drop, m_to, m_corr_age;
    bit m_cs;

    task automatic model_reset();
        m_state = 0; m_prev = 0; m_fc = 0; m_drop = 0; m_to = 0; m_corr_age = 0; m_cs = 0;
    endtask

    // Phase after one clock given this cycle's inputs.
    task automatic model_step(input bit tm, input int addr, input bit done);
        bit eof;
        int nxt;
        eof = (addr == FP - 1) && (addr != m_prev);
        m_prev = addr;
        nxt = m_state;
        m_cs = 0;
        if (m_state == 4) begin
            if (eof) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
            if (done) begin
                m_fc = (m_fc + 1) % 65536;
                nxt = tm ? 1 : 0;
            end
`ifdef FRAME_SCHEDULER_WATCHDOG_EN
            else if (m_corr_age == WD - 1) begin
                m_to = 1;
                nxt = tm ? 1 : 0;
            end
`endif
            else if (!tm) nxt = 0;
            m_corr_age++;
        end else if (!tm) begin
            nxt = 0;
        end else if (m_state == 0) begin
            nxt = 1;
        end else if (m_state == 3) begin
            nxt = 4;
            m_cs = 1;
        end else if (eof) begin
            nxt = m_state + 1;
        end
        if (nxt == 4 && m_state != 4) m_corr_age = 0;
        m_state = nxt;
    endtask

    task automatic test_random();
        int r;
        int shown = 0;
        logic [2:0] e_state;
        logic e_we, e_fz;
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(29, 0) == 0) tracking_mode = ~tracking_mode;
            corr_done = ($urandom_range(15, 0) == 0);
            r = $urandom_range(7, 0);
            if (r < 6) cap_addr = (cap_addr == 19'(FP - 1)) ? 19'd0 : cap_addr + 19'd1;
            else if (r == 7) cap_addr = 19'($urandom_range(FP - 1, 0));
            model_step(tracking_mode, int'(cap_addr), corr_done);
            tick();
            e_state = 3'(m_state);
            e_we = (m_state == 2);
            e_fz = (m_state == 3) || (m_state == 4);
            checks++;
            if (state !== e_state || static_we !== e_we || corr_start !== m_cs || frozen !== e_fz ||
                frame_count !== 16'(m_fc) || dropped !== 8'(m_drop) || timeout !== 1'(m_to)) begin
                errors++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random_cycle%0d: got st=%0d we=%b cs=%b fz=%b fc=%0d dr=%0d to=%b exp st=%0d we=%b cs=%b fz=%b fc=%0d dr=%0d to=%0d",
                             cyc, state, static_we, corr_start, frozen, frame_count, dropped, timeout,
                             e_state, e_we, m_cs, e_fz, m_fc, m_drop, m_to);
                end
            end
        end
        corr_done = 1'b0;
        $display("test_random: 3000 cycles, model fc=%0d dropped=%0d timeout=%0d", m_fc, m_drop, m_to);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold_eof();
        test_abort();
        test_dropped();
        test_watchdog();
        test_ignored_done();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_time_limit: simulation exceeded time bound");
        $fatal(1, "time limit");
    end

endmodule
